// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: pipelined reads on the inst SRAM port feeding an in-order PC/inst queue toward ID.
// Optional same-cycle response bypass to ID is enabled by defining IFQ_BYPASS_EN.
module if_fetch_queue #(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [64:0] if_to_id_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [3:0]  inst_sram_wstrb,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]           pc_q   [FIFO_DEPTH];
  logic [31:0]           inst_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] adef_q;
  logic [FIFO_DEPTH-1:0] filled_q;

  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic [AW-1:0] fill_ptr;
  logic [NW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [31:0]   fetch_pc;
  logic          adef_hold;
  logic          boot;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          q_full;
  logic          q_empty;
  logic [CW:0]   inflight;
  logic          credit_ok;
  logic          aligned;
  logic          issue;
  logic          adef_alloc;
  logic          alloc;
  logic          fill;
  logic          adef_fill_adv;
  logic          bypass_hit;
  logic          head_valid;
  logic          pop;

  assign redirect    = flush_valid | br_valid;
  assign redirect_pc = flush_valid ? flush_pc : br_target;

  assign q_full    = (count == NW'(FIFO_DEPTH));
  assign q_empty   = (count == '0);
  assign inflight  = {1'b0, outstanding} + {1'b0, discard_cnt};
  assign credit_ok = (inflight < (CW + 1)'(MAX_OUTSTANDING));
  assign aligned   = (fetch_pc[1:0] == 2'b00);

  // boot keeps the request low for the first cycle after reset is released
  assign inst_sram_req = resetn & boot & ~redirect & ~br_stall & ~adef_hold &
                         aligned & credit_ok & ~q_full;
  assign issue         = inst_sram_req & inst_sram_addr_ok;

  assign adef_alloc = resetn & boot & ~redirect & ~adef_hold & ~aligned & ~q_full;
  assign alloc      = issue | adef_alloc;

  // Responses arriving during a redirect are dropped and folded into discard_cnt
  assign fill = inst_sram_data_ok & (discard_cnt == '0) & ~redirect;

  // An adef entry is born filled; the fill pointer hops over it only when nothing ahead is unfilled
  assign adef_fill_adv = adef_alloc & (outstanding == CW'(fill));

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = fill & ~q_empty & (fill_ptr == head_ptr);
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_valid     = ~q_empty & filled_q[head_ptr];
  assign if_to_id_valid = resetn & (head_valid | bypass_hit);
  assign pop            = if_to_id_valid & id_allowin;

  assign if_to_id_bus = {pc_q[head_ptr],
                         bypass_hit ? inst_sram_rdata : inst_q[head_ptr],
                         bypass_hit ? 1'b0 : adef_q[head_ptr]};

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      filled_q    <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      fetch_pc    <= RESET_PC;
      adef_hold   <= 1'b0;
      boot        <= 1'b0;
    end else begin
      boot <= 1'b1;
      if (redirect) begin
        head_ptr    <= '0;
        tail_ptr    <= '0;
        fill_ptr    <= '0;
        count       <= '0;
        filled_q    <= '0;
        outstanding <= '0;
        discard_cnt <= discard_cnt + outstanding + CW'(issue) - CW'(inst_sram_data_ok);
        fetch_pc    <= redirect_pc;
        adef_hold   <= 1'b0;
      end else begin
        if (alloc) begin
          filled_q[tail_ptr] <= adef_alloc;
          tail_ptr           <= tail_ptr + AW'(1);
        end
        if (fill) begin
          filled_q[fill_ptr] <= 1'b1;
        end
        fill_ptr    <= fill_ptr + AW'(fill) + AW'(adef_fill_adv);
        head_ptr    <= head_ptr + AW'(pop);
        count       <= count + NW'(alloc) - NW'(pop);
        outstanding <= outstanding + CW'(issue) - CW'(fill);
        if (inst_sram_data_ok && (discard_cnt != '0)) begin
          discard_cnt <= discard_cnt - CW'(1);
        end
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (adef_alloc) begin
          adef_hold <= 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset; validity lives in filled_q and the pointers
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[tail_ptr]   <= fetch_pc;
      inst_q[tail_ptr] <= 32'h0;
      adef_q[tail_ptr] <= adef_alloc;
    end
    if (fill) begin
      inst_q[fill_ptr] <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: in-order SRAM slave model with 1-cycle response latency.
// Expected latency to ID follows IFQ_BYPASS_EN when the bench is built with it.
module tb_if_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        br_stall;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [64:0] if_to_id_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [3:0]  inst_sram_wstrb;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_fetch_queue dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush_valid       (flush_valid),
    .flush_pc          (flush_pc),
    .br_valid          (br_valid),
    .br_target         (br_target),
    .br_stall          (br_stall),
    .id_allowin        (id_allowin),
    .if_to_id_valid    (if_to_id_valid),
    .if_to_id_bus      (if_to_id_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Slave: accepts every request, answers in order one cycle later while resp_en is high
  logic [31:0] sl_addr [0:7];
  int          sl_cnt = 0;
  logic        resp_en;

  assign inst_sram_data_ok = resp_en && (sl_cnt > 0);
  assign inst_sram_rdata   = (sl_cnt > 0) ? ~sl_addr[0] : 32'h0;

  always @(posedge clk) begin
    int n;
    if (!resetn) begin
      sl_cnt <= 0;
    end else begin
      n = sl_cnt;
      if (inst_sram_data_ok) begin
        for (int i = 0; i < 7; i++) sl_addr[i] <= sl_addr[i+1];
        n = n - 1;
      end
      if (inst_sram_req && inst_sram_addr_ok) sl_addr[n] <= inst_sram_addr;
      sl_cnt <= n + ((inst_sram_req && inst_sram_addr_ok) ? 1 : 0);
    end
  end

  logic [64:0] dlog [$];
  int          dcyc [$];
  logic [31:0] rlog [$];
  int          cyc = 0;
  int          first_valid = -1;
  int          first_dok = -1;
  int          checks = 0;
  int          errors = 0;
  int          mark;
  int          rmark;

  function automatic logic [64:0] exp_bus(input logic [31:0] pc);
    return {pc, ~pc, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    #1;
    if (resetn) begin
      if (if_to_id_valid && id_allowin) begin
        dlog.push_back(if_to_id_bus);
        dcyc.push_back(cyc);
      end
      if (inst_sram_req && inst_sram_addr_ok) rlog.push_back(inst_sram_addr);
      if (if_to_id_valid && first_valid < 0) first_valid = cyc;
      if (inst_sram_data_ok && first_dok < 0) first_dok = cyc;
    end
  endtask

  task automatic next();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      next();
    end
  endtask

  initial begin
    resetn = 1'b0; flush_valid = 1'b0; flush_pc = '0; br_valid = 1'b0; br_target = '0;
    br_stall = 1'b0; id_allowin = 1'b1; inst_sram_addr_ok = 1'b1; resp_en = 1'b1;
    @(negedge clk);

    // reset cycles
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("reset_valid", 65'(if_to_id_valid), 65'd0);
      chk("reset_req", 65'(inst_sram_req), 65'd0);
      next();
    end
    chk("const_wr", 65'(inst_sram_wr), 65'd0);
    chk("const_wstrb", 65'(inst_sram_wstrb), 65'd0);
    chk("const_size", 65'(inst_sram_size), 65'd2);
    chk("const_wdata", 65'(inst_sram_wdata), 65'd0);

    // T1: streaming fetch
    resetn = 1'b1;
    sample();
    chk("post_reset_req", 65'(inst_sram_req), 65'd0);
    chk("post_reset_valid", 65'(if_to_id_valid), 65'd0);
    next();
    run(12);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 65'(rlog[i]), 65'(32'h1c000000 + 32'(4 * i)));
      chk("t1_bus", dlog[i], exp_bus(32'h1c000000 + 32'(4 * i)));
    end
    chk("t1_rate", 65'(dcyc[3] - dcyc[0]), 65'd3);
    chk("t6_latency", 65'(first_valid - first_dok), 65'(LAT));

    // T2: ID back-pressure fills the queue
    id_allowin = 1'b0;
    run(10);
    sample();
    chk("t2_held", 65'(rlog.size() - dlog.size()), 65'd4);
    chk("t2_req_full", 65'(inst_sram_req), 65'd0);
    chk("t2_valid_full", 65'(if_to_id_valid), 65'd1);
    next();
    id_allowin = 1'b1;
    run(12);
    for (int i = 0; i < dlog.size(); i++)
      chk("t2_order", dlog[i], exp_bus(32'h1c000000 + 32'(4 * i)));

    // T3: flush with two reads outstanding
    resp_en = 1'b0;
    run(4);
    sample();
    chk("t3_req_blocked", 65'(inst_sram_req), 65'd0);
    chk("t3_outstanding", 65'(dut.outstanding), 65'd2);
    next();
    flush_valid = 1'b1; flush_pc = 32'h1c008000;
    sample();
    chk("t3_req_redirect", 65'(inst_sram_req), 65'd0);
    mark = dlog.size();
    next();
    flush_valid = 1'b0; resp_en = 1'b1;
    sample();
    chk("t3_discard", 65'(dut.discard_cnt), 65'd2);
    next();
    run(8);
    chk("t3_first", dlog[mark], exp_bus(32'h1c008000));
    chk("t3_second", dlog[mark+1], exp_bus(32'h1c008004));
    chk("t3_discard_zero", 65'(dut.discard_cnt), 65'd0);

    // T4: misaligned branch target raises adef and stops fetching
    br_valid = 1'b1; br_target = 32'h1c000102;
    sample();
    mark = dlog.size();
    rmark = rlog.size();
    next();
    br_valid = 1'b0;
    run(8);
    chk("t4_adef", dlog[mark], {32'h1c000102, 32'h0, 1'b1});
    chk("t4_single", 65'(dlog.size() - mark), 65'd1);
    chk("t4_no_req", 65'(rlog.size() - rmark), 65'd0);
    sample();
    chk("t4_req_held", 65'(inst_sram_req), 65'd0);
    next();
    br_valid = 1'b1; br_target = 32'h1c000200;
    sample();
    mark = dlog.size();
    next();
    br_valid = 1'b0;
    run(8);
    chk("t4_resume", dlog[mark], exp_bus(32'h1c000200));
    chk("t4_resume2", dlog[mark+1], exp_bus(32'h1c000204));

    // T5: flush beats branch in the same cycle
    flush_valid = 1'b1; flush_pc = 32'h1c008000;
    br_valid = 1'b1; br_target = 32'h1c000400;
    sample();
    mark = dlog.size();
    next();
    flush_valid = 1'b0; br_valid = 1'b0;
    run(8);
    chk("t5_flush_wins", dlog[mark], exp_bus(32'h1c008000));
    chk("t5_next", dlog[mark+1], exp_bus(32'h1c008004));

    // T7: reset in the middle of streaming
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("mid_reset_valid", 65'(if_to_id_valid), 65'd0);
      chk("mid_reset_req", 65'(inst_sram_req), 65'd0);
      next();
    end
    resetn = 1'b1;
    dlog.delete(); dcyc.delete(); rlog.delete();
    first_valid = -1; first_dok = -1;
    sample();
    chk("mid_post_req", 65'(inst_sram_req), 65'd0);
    next();
    run(8);
    chk("mid_first", dlog[0], exp_bus(32'h1c000000));
    chk("mid_second", dlog[1], exp_bus(32'h1c000004));
    chk("mid_latency", 65'(first_valid - first_dok), 65'(LAT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
